apb_rr_arbiter: RTL and testbench

APB_RR_ARBITER -- requirements
Module: apb_rr_arbiter

---
 rtl/apb_arb_pkg.sv | 8 +
 rtl/apb_rr_arbiter_if.sv | 23 ++
 rtl/apb_rr_pick.sv | 21 ++
 rtl/apb_rr_arbiter.sv | 84 ++++++++
 tb/tb_apb_rr_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared FSM states, timeout length and default widths for the APB round-robin arbiter
package apb_arb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int DEF_NREQ = 4;
  localparam int DEF_AW = 8;
  localparam int DEF_DW = 32;
endpackage

// File: rtl/apb_rr_arbiter_if.sv
// apb_rr_arbiter_if: requester-side and APB-side signals of the arbiter; master is the arbiter view
interface apb_rr_arbiter_if
  import apb_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  logic [NREQ-1:0] req_valid, req_write, req_ready, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, PWDATA, PRDATA;
  logic [AW-1:0] PADDR;
  logic rsp_err, PSEL, PENABLE, PWRITE, PREADY;
  modport master (
    input req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_rr_pick.sv
// apb_rr_pick: first set request at or above ptr, wrapping, as one-hot grant plus index
module apb_rr_pick
  import apb_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);
  always_comb begin
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[IW'((int'(ptr) + i) % NREQ)]) idx = IW'((int'(ptr) + i) % NREQ);
  end
  assign any = |req;
  assign gnt = any ? NREQ'(1) << idx : '0;
endmodule

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter: round-robin arbitration of NREQ requesters onto one APB completer.
// Define APB_ARB_TIMEOUT_EN to end a stalled ACCESS after TIMEOUT_CYCLES with rsp_err=1.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input logic PCLK,
  input logic PRESET,
  apb_rr_arbiter_if.master bus
);
  localparam int IW = $clog2(NREQ);
  state_t state;
  logic [IW-1:0] rr_ptr, owner, idx;
  logic [NREQ-1:0] gnt;
  logic any, tmo, done;
  apb_rr_pick #(.NREQ(NREQ)) u_pick (.req(bus.req_valid), .ptr(rr_ptr), .gnt, .idx, .any);
`ifdef APB_ARB_TIMEOUT_EN
  logic [4:0] cnt;
  assign tmo = cnt == 5'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif
  assign done = bus.PREADY || tmo;
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
      bus.PSEL <= 1'b0;
      bus.PENABLE <= 1'b0;
      bus.PWRITE <= 1'b0;
      bus.PADDR <= '0;
      bus.PWDATA <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt <= '0;
      bus.rsp_err <= 1'b0;
`endif
    end else begin
      bus.req_ready <= '0;
      bus.rsp_valid <= '0;
      case (state)
        IDLE: if (any) begin
          state <= SETUP;
          owner <= idx;
          bus.req_ready <= gnt;
          bus.PSEL <= 1'b1;
          bus.PWRITE <= bus.req_write[idx];
          bus.PADDR <= bus.req_addr[int'(idx)*AW +: AW];
          bus.PWDATA <= bus.req_wdata[int'(idx)*DW +: DW];
        end
        SETUP: begin
          state <= ACCESS;
          bus.PENABLE <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        ACCESS: begin
          if (done) begin
            state <= IDLE;
            bus.PSEL <= 1'b0;
            bus.PENABLE <= 1'b0;
            bus.rsp_valid <= NREQ'(1) << owner;
            bus.rsp_rdata <= (bus.PREADY && !bus.PWRITE) ? bus.PRDATA : '0;
            rr_ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
            bus.rsp_err <= !bus.PREADY;
`endif
          end
`ifdef APB_ARB_TIMEOUT_EN
          cnt <= cnt + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb_apb_rr_arbiter: scoreboard-checked bench for apb_rr_arbiter (honours APB_ARB_TIMEOUT_EN)
module tb_apb_rr_arbiter;
  localparam int NREQ = 4, AW = 8, DW = 32;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  typedef struct {
    int idx;
    logic [DW-1:0] rdata;
    logic err;
  } rsp_t;
  rsp_t exp_q[$];

  apb_rr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus();
  apb_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (.PCLK(clk), .PRESET(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic idle_inputs;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.PRDATA = '0;
    bus.PREADY = 1'b0;
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    bus.req_valid[1] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b, want 000", {bus.PSEL, bus.PENABLE, bus.PWRITE});
    end
    checks++;
    if (bus.PADDR !== '0 || bus.PWDATA !== '0) begin
      errors++; $display("FAIL reset_addr_data: got %h/%h, want 0/0", bus.PADDR, bus.PWDATA);
    end
    checks++;
    if (bus.req_ready !== '0 || bus.rsp_valid !== '0) begin
      errors++; $display("FAIL reset_handshake: got %b/%b, want 0/0", bus.req_ready, bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_rdata !== '0 || bus.rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_rsp: got %h/%b, want 0/0", bus.rsp_rdata, bus.rsp_err);
    end
    bus.req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_xfer(input int idx, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int waits, input logic [DW-1:0] rd);
    rsp_t e;
    int n;
    exp_q.push_back('{idx, wr ? 32'h0 : rd, 1'b0});
    bus.req_valid[idx] = 1'b1;
    bus.req_write[idx] = wr;
    bus.req_addr[idx*AW +: AW] = addr;
    bus.req_wdata[idx*DW +: DW] = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.req_ready == '0 && n < 20);
    bus.req_valid[idx] = 1'b0;
    checks++;
    if (n !== 1) begin errors++; $display("FAIL accept_latency req%0d: got %0d cycles, want 1", idx, n); end
    checks++;
    if (bus.req_ready !== NREQ'(1) << idx) begin
      errors++; $display("FAIL req_ready req%0d: got %b", idx, bus.req_ready);
    end
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== {2'b10, wr}) begin
      errors++; $display("FAIL setup_ctrl req%0d: got %b, want %b", idx, {bus.PSEL, bus.PENABLE, bus.PWRITE}, {2'b10, wr});
    end
    checks++;
    if (bus.PADDR !== addr || (wr && bus.PWDATA !== wd)) begin
      errors++; $display("FAIL setup_addr req%0d: got %h/%h, want %h/%h", idx, bus.PADDR, bus.PWDATA, addr, wd);
    end
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.PSEL, bus.PENABLE} !== 2'b11 || bus.PADDR !== addr || bus.rsp_valid !== '0) begin
        errors++; $display("FAIL access%0d req%0d: got sel/en %b addr %h rsp %b", k, idx, {bus.PSEL, bus.PENABLE}, bus.PADDR, bus.rsp_valid);
      end
      bus.PREADY = (k == waits);
      bus.PRDATA = (k == waits) ? rd : 32'h0BAD_0000;
    end
    @(negedge clk);
    bus.PREADY = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (bus.rsp_valid !== NREQ'(1) << e.idx) begin
      errors++; $display("FAIL rsp_valid req%0d: got %b, want index %0d", idx, bus.rsp_valid, e.idx);
    end
    checks++;
    if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
      errors++; $display("FAIL rsp_data req%0d: got %h/%b, want %h/%b", idx, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
    end
    checks++;
    if ({bus.PSEL, bus.PENABLE} !== 2'b00) begin
      errors++; $display("FAIL idle_ctrl req%0d: got %b, want 00", idx, {bus.PSEL, bus.PENABLE});
    end
  endtask

  task automatic test_single_write;
    do_xfer(0, 1'b1, 8'h10, 32'hDEADBEEF, 0, 32'h0);
  endtask

  task automatic test_read_wait;
    do_xfer(2, 1'b0, 8'h20, 32'h0, 2, 32'h1234_5678);
  endtask

  task automatic test_all_four;
    int order[5] = '{0, 1, 2, 3, 0};
    rsp_t e;
    int n;
    apply_reset();
    for (int i = 0; i < NREQ; i++) bus.req_addr[i*AW +: AW] = 8'h40 + 8'(i);
    bus.req_valid = '1;
    for (int j = 0; j < 5; j++) exp_q.push_back('{order[j], 32'hA000_0000 + 32'(j), 1'b0});
    for (int j = 0; j < 5; j++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (bus.req_ready == '0 && n < 20);
      e = exp_q[0];
      checks++;
      if (bus.req_ready !== NREQ'(1) << e.idx || bus.PADDR !== 8'h40 + 8'(e.idx)) begin
        errors++; $display("FAIL grant%0d: got %b addr %h, want index %0d", j, bus.req_ready, bus.PADDR, e.idx);
      end
      @(negedge clk);
      bus.PREADY = 1'b1;
      bus.PRDATA = 32'hA000_0000 + 32'(j);
      @(negedge clk);
      bus.PREADY = 1'b0;
      if (j == 4) bus.req_valid = '0;
      e = exp_q.pop_front();
      checks++;
      if (bus.rsp_valid !== NREQ'(1) << e.idx || bus.rsp_rdata !== e.rdata) begin
        errors++; $display("FAIL rr_rsp%0d: got %b/%h, want index %0d/%h", j, bus.rsp_valid, bus.rsp_rdata, e.idx, e.rdata);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    rsp_t e;
    int n;
    bus.req_valid[3] = 1'b1;
    bus.req_write[3] = 1'b1;
    bus.req_addr[3*AW +: AW] = 8'h33;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.req_ready == '0 && n < 20);
    checks++;
    if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL mid_accept: got %b, want 1000", bus.req_ready); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.PSEL, bus.PENABLE} !== 2'b00 || bus.rsp_valid !== '0) begin
      errors++; $display("FAIL mid_reset_abort: got sel/en %b rsp %b, want 00/0000", {bus.PSEL, bus.PENABLE}, bus.rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.PREADY = 1'b1;
    bus.req_valid[0] = 1'b1;
    bus.req_write[0] = 1'b0;
    bus.req_addr[0 +: AW] = 8'h50;
    bus.PRDATA = 32'h0000_CAFE;
    exp_q.push_back('{0, 32'h0000_CAFE, 1'b0});
    n = 0;
    do begin
      @(negedge clk); n++;
      checks++;
      if (bus.rsp_valid !== '0) begin errors++; $display("FAIL mid_no_rsp: got %b, want 0000", bus.rsp_valid); end
    end while (bus.req_ready == '0 && n < 20);
    bus.req_valid[0] = 1'b0;
    checks++;
    if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_regrant: got %b, want 0001", bus.req_ready); end
    repeat (2) @(negedge clk);
    bus.PREADY = 1'b0;
    bus.req_valid[3] = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (bus.rsp_valid !== NREQ'(1) << e.idx || bus.rsp_rdata !== e.rdata) begin
      errors++; $display("FAIL mid_rsp: got %b/%h, want index %0d/%h", bus.rsp_valid, bus.rsp_rdata, e.idx, e.rdata);
    end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== '0 || bus.PSEL !== 1'b0) begin
      errors++; $display("FAIL dropped_req: got ready %b sel %b, want 0000/0", bus.req_ready, bus.PSEL);
    end
  endtask

  task automatic test_timeout;
    rsp_t e;
    int n;
    int bad;
`ifdef APB_ARB_TIMEOUT_EN
    exp_q.push_back('{1, 32'h0, 1'b1});
`else
    exp_q.push_back('{1, 32'h5A5A_5A5A, 1'b0});
`endif
    bus.req_valid[1] = 1'b1;
    bus.req_write[1] = 1'b0;
    bus.req_addr[1*AW +: AW] = 8'h60;
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'hFFFF_FFFF;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.req_ready == '0 && n < 20);
    bus.req_valid[1] = 1'b0;
    checks++;
    if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL to_accept: got %b, want 0010", bus.req_ready); end
`ifdef APB_ARB_TIMEOUT_EN
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) break;
      n += int'(bus.PENABLE);
    end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL to_cycles: got %0d access cycles, want 16", n); end
`else
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.PENABLE !== 1'b1 || bus.rsp_valid !== '0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL to_hold: got %0d bad cycles, want 0", bad); end
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'h5A5A_5A5A;
    @(negedge clk);
    bus.PREADY = 1'b0;
`endif
    e = exp_q.pop_front();
    checks++;
    if (bus.rsp_valid !== NREQ'(1) << e.idx || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
      errors++; $display("FAIL to_rsp: got %b/%h/%b, want index %0d/%h/%b", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, e.idx, e.rdata, e.err);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_all_four();
    test_reset_mid();
    test_timeout();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
